// File: rtl/half_adder_pkg.sv
// Shared constants for the half adder slice.
// Holds the default lane count and the reset value of the output registers.
package half_adder_pkg;

    localparam int   DEFAULT_WIDTH = 1;
    localparam logic RST_VAL       = 1'b0;

endpackage : half_adder_pkg

// File: rtl/half_adder_bit.sv
// Single-lane half adder cell: sum = a ^ b, carry = a & b.
module half_adder_bit (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule : half_adder_bit

// File: rtl/half_adder.sv
// WIDTH-lane bitwise half adder with combinational taps and an optional
// one-cycle output register stage qualified by in_valid.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum_comb,
    output logic [WIDTH-1:0] carry_comb
);

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_bit u_bit (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum_comb[i]),
            .carry (carry_comb[i])
        );
    end

    // Reset has priority over capture; without in_valid the result is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= {WIDTH{RST_VAL}};
            carry_q <= {WIDTH{RST_VAL}};
            valid_q <= RST_VAL;
        end else begin
            if (in_valid) begin
                sum_q   <= sum_comb;
                carry_q <= carry_comb;
            end
            valid_q <= in_valid;
        end
    end

    assign sum       = REGISTERED ? sum_q   : sum_comb;
    assign carry     = REGISTERED ? carry_q : carry_comb;
    assign out_valid = REGISTERED ? valid_q : in_valid;

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: four instances covering the
// combinational and registered modes at widths 1, 4 and 8.
module tb_half_adder;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] c;
        logic       v;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sc;
        logic [7:0] exp_cc;
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic       exp_v;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       iv8 = 1'b0;
    logic [7:0] s8, c8, sc8, cc8;
    logic       ov8;

    logic [3:0] a4 = '0, b4 = '0;
    logic       iv4 = 1'b0;
    logic [3:0] s4, c4, sc4, cc4;
    logic       ov4;

    logic [0:0] a1c = '0, b1c = '0;
    logic       iv1c = 1'b0;
    logic [0:0] s1c, c1c, sc1c, cc1c;
    logic       ov1c;

    logic [0:0] a1r = '0, b1r = '0;
    logic       iv1r = 1'b0;
    logic [0:0] s1r, c1r, sc1r, cc1r;
    logic       ov1r;

    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    half_adder #(.WIDTH(8), .REGISTERED(1'b1)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8),
        .sum(s8), .carry(c8), .out_valid(ov8), .sum_comb(sc8), .carry_comb(cc8));

    half_adder #(.WIDTH(4), .REGISTERED(1'b1)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4),
        .sum(s4), .carry(c4), .out_valid(ov4), .sum_comb(sc4), .carry_comb(cc4));

    half_adder #(.WIDTH(1), .REGISTERED(1'b0)) u1c (
        .clk(clk), .rst(rst), .in_valid(iv1c), .a(a1c), .b(b1c),
        .sum(s1c), .carry(c1c), .out_valid(ov1c), .sum_comb(sc1c), .carry_comb(cc1c));

    half_adder #(.WIDTH(1), .REGISTERED(1'b1)) u1r (
        .clk(clk), .rst(rst), .in_valid(iv1r), .a(a1r), .b(b1r),
        .sum(s1r), .carry(c1r), .out_valid(ov1r), .sum_comb(sc1r), .carry_comb(cc1r));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vec_t  tbl[8];
        exp_t  e;
        logic [0:0] pa[4];
        logic [0:0] pb[4];
        logic [0:0] es[4];
        logic [0:0] ec[4];

        tbl[0] = '{1'b0, 1'b1, 8'hF0, 8'hCC, 8'h3C, 8'hC0, 8'h3C, 8'hC0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h3C, 8'hC0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h0F, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h0F, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 8'h12, 8'h34, 8'h26, 8'h10, 8'hFF, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h81, 8'h01, 8'h80, 8'h01, 8'h80, 8'h01, 1'b1};

        pa = '{1'b0, 1'b0, 1'b1, 1'b1};
        pb = '{1'b0, 1'b1, 1'b0, 1'b1};
        es = '{1'b0, 1'b1, 1'b1, 1'b0};
        ec = '{1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held for two edges, inputs idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s8",  s8,  8'h00);
        chk("rst_c8",  c8,  8'h00);
        chk("rst_v8",  {7'b0, ov8}, 8'h00);
        chk("rst_s4",  {4'b0, s4}, 8'h00);
        chk("rst_c4",  {4'b0, c4}, 8'h00);
        chk("rst_s1r", {7'b0, s1r}, 8'h00);
        chk("rst_c1r", {7'b0, c1r}, 8'h00);
        chk("rst_v1r", {7'b0, ov1r}, 8'h00);

        // Combinational mode ignores rst: first two vectors run with rst still high.
        for (int i = 0; i < 4; i++) begin
            a1c  = pa[i];
            b1c  = pb[i];
            iv1c = i[0];
            if (i == 2) rst = 1'b0;
            #1;
            chk("w1c_sum",   {7'b0, s1c},  {7'b0, es[i]});
            chk("w1c_carry", {7'b0, c1c},  {7'b0, ec[i]});
            chk("w1c_valid", {7'b0, ov1c}, {7'b0, i[0]});
            chk("w1c_sumc",  {7'b0, sc1c}, {7'b0, es[i]});
            chk("w1c_inv",   {7'b0, s1c & c1c}, 8'h00);
        end
        rst = 1'b0;

        // Width-1 registered: 11 captured, visible one cycle later.
        @(negedge clk);
        a1r = 1'b1; b1r = 1'b1; iv1r = 1'b1;
        #1;
        chk("w1r_pre_v", {7'b0, ov1r}, 8'h00);
        @(negedge clk);
        chk("w1r_sum",   {7'b0, s1r},  8'h00);
        chk("w1r_carry", {7'b0, c1r},  8'h01);
        chk("w1r_valid", {7'b0, ov1r}, 8'h01);
        iv1r = 1'b0;

        // Width-8 table through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst;
            iv8 = tbl[i].iv;
            a8  = tbl[i].a;
            b8  = tbl[i].b;
            #1;
            chk("w8_sumc",   sc8, tbl[i].exp_sc);
            chk("w8_carryc", cc8, tbl[i].exp_cc);
            q8.push_back('{tbl[i].exp_s, tbl[i].exp_c, tbl[i].exp_v});
            @(negedge clk);
            if (q8.size() == 0) begin
                chk("w8_queue_empty", 8'h01, 8'h00);
            end else begin
                e = q8.pop_front();
                chk("w8_sum",   s8, e.s);
                chk("w8_carry", c8, e.c);
                chk("w8_valid", {7'b0, ov8}, {7'b0, e.v});
                chk("w8_inv",   s8 & c8, 8'h00);
            end
        end
        rst = 1'b0;
        iv8 = 1'b0;

        // Width-4 exhaustive, back-to-back captures.
        iv4 = 1'b1;
        for (int p = 0; p < 256; p++) begin
            a4 = p[7:4];
            b4 = p[3:0];
            #1;
            chk("w4_sumc",   {4'b0, sc4}, {4'b0, a4 ^ b4});
            chk("w4_carryc", {4'b0, cc4}, {4'b0, a4 & b4});
            chk("w4_invc",   {4'b0, sc4 & cc4}, 8'h00);
            q4.push_back('{{4'b0, a4 ^ b4}, {4'b0, a4 & b4}, 1'b1});
            @(negedge clk);
            e = q4.pop_front();
            chk("w4_sum",   {4'b0, s4}, e.s);
            chk("w4_carry", {4'b0, c4}, e.c);
            chk("w4_valid", {7'b0, ov4}, {7'b0, e.v});
            chk("w4_inv",   {4'b0, s4 & c4}, 8'h00);
        end
        iv4 = 1'b0;
        @(negedge clk);
        chk("w4_drop_valid", {7'b0, ov4}, 8'h00);
        chk("w4_hold_carry", {4'b0, c4}, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_half_adder

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bitwise half adder for WIDTH independent lanes.
- Each lane: sum = a XOR b, carry = a AND b.
- Provides a zero-latency combinational result and a registered result (1-cycle latency) with a valid flag.
- Used as a leaf arithmetic cell for building full adders and ripple/carry-save structures, and as a pipelined operand stage.

Parameters:
- WIDTH, 1: number of independent 1-bit lanes (>= 1).
- REGISTERED, 1: 1 = sum/carry ports are the registered result; 0 = sum/carry ports are the combinational result and out_valid mirrors in_valid.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- in_valid  input  1  qualifies a/b for capture into the output register.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- sum  output  WIDTH  per-lane a XOR b (registered or combinational per REGISTERED).
- carry  output  WIDTH  per-lane a AND b (registered or combinational per REGISTERED).
- out_valid  output  1  sum/carry hold a result from a valid input.
- sum_comb  output  WIDTH  always-combinational a XOR b, independent of clk/rst.
- carry_comb  output  WIDTH  always-combinational a AND b, independent of clk/rst.

Behaviour:
- Lane truth table, bit i (a,b -> sum,carry):
  - 0,0 -> 0,0
  - 0,1 -> 1,0
  - 1,0 -> 1,0
  - 1,1 -> 0,1
- Lanes are fully independent; no carry propagates between lanes.
- sum_comb/carry_comb: pure combinational, settle within the same delta as a/b, unaffected by rst.
- REGISTERED=1:
  - On a rising edge with rst=1: sum=0, carry=0, out_valid=0 (all WIDTH bits cleared).
  - On a rising edge with rst=0 and in_valid=1: sum<=a^b, carry<=a&b, out_valid<=1. Latency is exactly 1 cycle.
  - On a rising edge with rst=0 and in_valid=0: sum/carry hold their previous values; out_valid<=0.
  - rst and in_valid both 1: reset wins and the input is dropped.
  - Reset asserted between captures clears the held result on the next edge; no partial update.
- REGISTERED=0:
  - sum=sum_comb, carry=carry_comb, out_valid=in_valid, all combinational.
  - rst has no effect on outputs.
- Invariant: sum & carry == 0 in every lane at all times, for both modes.
- X on a/b propagates only to the affected lanes. No X appears on registered outputs after reset until a valid capture.

Decomposition:
- Shared package half_adder_pkg: default WIDTH constant, and localparam RST_VAL = '0 for the output registers.
- One natural sub-module: half_adder_bit (1-bit combinational XOR/AND cell), instantiated WIDTH times via generate.
- The top level adds the generate loop, the output register bank, and the REGISTERED mux.

Test Plan:
- WIDTH=1, REGISTERED=0: drive (a,b) = 00, 01, 10, 11, one per time step -> (sum,carry) = 00, 10, 10, 01 and out_valid follows in_valid. After the final 11, sum=0, carry=1.
- WIDTH=1, REGISTERED=1: hold rst=1 for 2 cycles -> sum=0, carry=0, out_valid=0. Then apply 11 with in_valid=1 -> one cycle later sum=0, carry=1, out_valid=1.
- WIDTH=8, REGISTERED=1: a=8'hF0, b=8'hCC, in_valid=1 -> next cycle sum=8'h3C, carry=8'hC0. Meanwhile sum_comb=8'h3C and carry_comb=8'hC0 in the same cycle.
- Hold: after a capture, drop in_valid and change a/b to 8'hFF/8'hFF -> registered sum/carry unchanged, out_valid=0. sum_comb=8'h00, carry_comb=8'hFF.
- Simultaneous rst=1 and in_valid=1 with a=b=8'hFF -> sum=0, carry=0, out_valid=0 after the edge.
- Exhaustive WIDTH=4: all 256 a/b pairs -> every result matches a^b and a&b, and sum&carry==0 throughout.
